mem_wb_elastic: RTL and testbench

Parametrised, elastic MEM→WB pipeline stage: a DEPTH-entry in-order queue with valid/ready handshakes on both sides replaces the fixed enable/flush register. Writeback data (load vs ALU) is selected at enqueue. A register-indexed forwarding lookup searches all queued entries for the EX stage, and a retire counter tracks committed writebacks. It sits between the MEM stage and the register-file write port.

---
 rtl/mem_wb_elastic_pkg.sv | 16 +
 rtl/mem_wb_fwd_lookup.sv | 37 +++
 rtl/mem_wb_elastic.sv | 121 ++++++++++++
 tb/tb_mem_wb_elastic.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_elastic_pkg.sv
// MEM->WB shared pipeline types.
// Entry layout and widths used by the elastic WB queue.
package mem_wb_elastic_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [DATA_W-1:0] wb_data;
    logic [REG_AW-1:0] rd;
    logic              wb_en;
  } wb_entry_t;

  localparam wb_entry_t WB_ENTRY_ZERO = '0;

endpackage

// File: rtl/mem_wb_fwd_lookup.sv
// Forwarding lookup over the WB queue.
// Youngest valid entry writing rs wins.
module mem_wb_fwd_lookup
  import mem_wb_elastic_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH)
) (
  input  wb_entry_t         ents [DEPTH],
  input  logic [PW-1:0]     rd_ptr,
  input  logic [PW:0]       count,
  input  logic              en,
  input  logic [REG_AW-1:0] rs,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PW-1:0] idx;

  // oldest to youngest; later matches overwrite earlier ones
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (en && rs != '0 &&
          i < int'(count) &&
          ents[idx].wb_en &&
          ents[idx].rd == rs) begin
        hit  = 1'b1;
        data = ents[idx].wb_data;
      end
    end
  end

endmodule

// File: rtl/mem_wb_elastic.sv
// Elastic MEM->WB stage: in-order queue
// with forwarding lookup and retire counter.
module mem_wb_elastic #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int DEPTH   = 2,
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_alu_result,
  input  logic [DATA_W-1:0]  in_load_data,
  input  logic [REG_AW-1:0]  in_rd,
  input  logic               in_wb_en,
  input  logic               in_memtoreg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_wb_data,
  output logic [REG_AW-1:0]  out_rd,
  output logic               out_wb_en,
  input  logic [REG_AW-1:0]  fwd_rs,
  output logic               fwd_hit,
  output logic [DATA_W-1:0]  fwd_data,
  output logic [COUNT_W-1:0] retire_count
);

  import mem_wb_elastic_pkg::*;

  localparam int PW = $clog2(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     new_e;
  wb_entry_t     head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push;
  logic          pop;

  assign in_ready  = count != (PW+1)'(DEPTH);
  assign out_valid = (count != '0) && !flush;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  // select writeback data and squash x0 writes at enqueue
  always_comb begin
    new_e         = WB_ENTRY_ZERO;
    new_e.wb_data = in_memtoreg ? in_load_data
                                : in_alu_result;
    new_e.rd      = in_rd;
    new_e.wb_en   = in_wb_en && (in_rd != '0);
  end

  // head view, zero when empty
  always_comb begin
    head = WB_ENTRY_ZERO;
    if (count != '0) head = mem_q[rd_ptr];
  end

  assign out_wb_data = head.wb_data;
  assign out_rd      = head.rd;
  assign out_wb_en   = head.wb_en;

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + (PW+1)'(1);
      else if (pop && !push)
        count <= count - (PW+1)'(1);
    end
  end

  // entry storage; flush drops every pending write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= WB_ENTRY_ZERO;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i].wb_en <= 1'b0;
    end else if (push) begin
      mem_q[wr_ptr] <= new_e;
    end
  end

  // count committed register writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retire_count <= '0;
    else if (pop && head.wb_en)
      retire_count <= retire_count + COUNT_W'(1);
  end

  mem_wb_fwd_lookup #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_fwd (
    .ents   (mem_q),
    .rd_ptr (rd_ptr),
    .count  (count),
    .en     (!flush),
    .rs     (fwd_rs),
    .hit    (fwd_hit),
    .data   (fwd_data)
  );

endmodule

// File: tb/tb_mem_wb_elastic.sv
// Bench for mem_wb_elastic: directed table,
// queue-based model under random traffic, async reset.
module tb_mem_wb_elastic;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_result;
  logic [31:0] in_load_data;
  logic [4:0]  in_rd;
  logic        in_wb_en;
  logic        in_memtoreg;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_wb_data;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic [4:0]  fwd_rs;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [31:0] retire_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_elastic #(
    .DATA_W (32), .REG_AW (5),
    .DEPTH (DEPTH), .COUNT_W (32)
  ) dut (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_alu_result (in_alu_result),
    .in_load_data (in_load_data),
    .in_rd (in_rd), .in_wb_en (in_wb_en),
    .in_memtoreg (in_memtoreg),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_wb_data (out_wb_data), .out_rd (out_rd),
    .out_wb_en (out_wb_en), .fwd_rs (fwd_rs),
    .fwd_hit (fwd_hit), .fwd_data (fwd_data),
    .retire_count (retire_count)
  );

  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    logic        en;
  } ment_t;

  ment_t       q[$];
  int unsigned m_ret;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic check_model();
    logic        e_hit;
    logic [31:0] e_fd;
    ment_t       h;
    e_hit = 1'b0;
    e_fd  = '0;
    h     = '{0, 0, 0};
    if (q.size() != 0) h = q[0];
    if (!flush && fwd_rs != 0) begin
      for (int i = q.size() - 1; i >= 0; i--)
        if (!e_hit && q[i].en && q[i].rd == fwd_rs) begin
          e_hit = 1'b1;
          e_fd  = q[i].d;
        end
    end
    chk("m_in_ready", in_ready, q.size() != DEPTH);
    chk("m_out_valid", out_valid,
        q.size() != 0 && !flush);
    chk("m_out_data", out_wb_data, h.d);
    chk("m_out_rd", out_rd, h.rd);
    chk("m_out_wb_en", out_wb_en, h.en);
    chk("m_fwd_hit", fwd_hit, e_hit);
    chk("m_fwd_data", fwd_data, e_fd);
    chk("m_retire", retire_count, m_ret);
  endtask

  task automatic model_step();
    logic  rdy;
    ment_t e;
    rdy = q.size() != DEPTH;
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() != 0 && out_ready) begin
        if (q[0].en) m_ret++;
        void'(q.pop_front());
      end
      if (in_valid && rdy) begin
        e.d  = in_memtoreg ? in_load_data : in_alu_result;
        e.rd = in_rd;
        e.en = in_wb_en && in_rd != 0;
        q.push_back(e);
      end
    end
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        fl, iv;
    logic [31:0] alu, ld;
    logic [4:0]  rd;
    logic        we, m2r, ordy;
    logic [4:0]  rs;
    logic        x_ir, x_ov;
    logic [31:0] x_d;
    logic [4:0]  x_rd;
    logic        x_we, x_hit;
    logic [31:0] x_fd, x_ret;
  } vec_t;

  vec_t tv[$];

  task automatic add(logic fl, logic iv, logic [31:0] alu,
      logic [31:0] ld, logic [4:0] rd, logic we,
      logic m2r, logic ordy, logic [4:0] rs,
      logic x_ir, logic x_ov, logic [31:0] x_d,
      logic [4:0] x_rd, logic x_we, logic x_hit,
      logic [31:0] x_fd, logic [31:0] x_ret);
    vec_t v;
    v = '{fl, iv, alu, ld, rd, we, m2r, ordy, rs,
          x_ir, x_ov, x_d, x_rd, x_we, x_hit, x_fd, x_ret};
    tv.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_alu_result = '0; in_load_data = '0;
    in_rd = '0; in_wb_en = 1'b0; in_memtoreg = 1'b0;
    out_ready = 1'b0; fwd_rs = '0;
    q.delete(); m_ret = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_wb_data, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_retire", retire_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // fl iv alu ld rd we m2r ordy rs | ir ov d rd we hit fd ret
    add(0,1,32'h11,0,3,1,0,1,3,     1,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,1,3,          1,1,32'h11,3,1,1,32'h11,0);
    add(0,1,32'hBEEF,32'hDEAD,7,1,1,0,3, 1,0,0,0,0,0,0,1);
    add(0,0,0,0,0,0,0,0,7,          1,1,32'hDEAD,7,1,1,32'hDEAD,1);
    add(0,1,32'hA,0,5,1,0,0,5,      1,1,32'hDEAD,7,1,0,0,1);
    add(0,1,32'hB,0,5,1,0,0,5,      0,1,32'hDEAD,7,1,1,32'hA,1);
    add(0,1,32'hB,0,5,1,0,1,5,      0,1,32'hDEAD,7,1,1,32'hA,1);
    add(0,1,32'hB,0,5,1,0,0,5,      1,1,32'hA,5,1,1,32'hA,2);
    add(0,0,0,0,0,0,0,0,5,          0,1,32'hA,5,1,1,32'hB,2);
    add(0,0,0,0,0,0,0,0,0,          0,1,32'hA,5,1,0,0,2);
    add(1,1,32'h33,0,9,1,0,1,5,     0,0,32'hA,5,1,0,0,2);
    add(0,0,0,0,0,0,0,1,5,          1,0,0,0,0,0,0,2);
    add(0,1,32'h44,0,0,1,0,0,0,     1,0,0,0,0,0,0,2);
    add(0,0,0,0,0,0,0,1,0,          1,1,32'h44,0,0,0,0,2);
    add(0,0,0,0,0,0,0,1,0,          1,0,0,0,0,0,0,2);

    foreach (tv[k]) begin
      flush = tv[k].fl; in_valid = tv[k].iv;
      in_alu_result = tv[k].alu; in_load_data = tv[k].ld;
      in_rd = tv[k].rd; in_wb_en = tv[k].we;
      in_memtoreg = tv[k].m2r; out_ready = tv[k].ordy;
      fwd_rs = tv[k].rs;
      @(negedge clk);
      chk($sformatf("t%0d_in_ready", k), in_ready, tv[k].x_ir);
      chk($sformatf("t%0d_out_valid", k), out_valid, tv[k].x_ov);
      chk($sformatf("t%0d_out_data", k), out_wb_data, tv[k].x_d);
      chk($sformatf("t%0d_out_rd", k), out_rd, tv[k].x_rd);
      chk($sformatf("t%0d_out_we", k), out_wb_en, tv[k].x_we);
      chk($sformatf("t%0d_fwd_hit", k), fwd_hit, tv[k].x_hit);
      chk($sformatf("t%0d_fwd_data", k), fwd_data, tv[k].x_fd);
      chk($sformatf("t%0d_retire", k), retire_count, tv[k].x_ret);
      check_model();
      finish_cycle();
    end

    for (int c = 0; c < 400; c++) begin
      flush         = ($urandom_range(0, 19) == 0);
      in_valid      = $urandom_range(0, 1);
      in_alu_result = $urandom;
      in_load_data  = $urandom;
      in_rd         = 5'($urandom_range(0, 3));
      in_wb_en      = ($urandom_range(0, 3) != 0);
      in_memtoreg   = $urandom_range(0, 1);
      out_ready     = $urandom_range(0, 1);
      fwd_rs        = 5'($urandom_range(0, 3));
      @(negedge clk);
      check_model();
      finish_cycle();
    end

    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    in_wb_en = 1'b1; in_memtoreg = 1'b0; in_rd = 5'd6;
    in_alu_result = 32'h66; fwd_rs = 5'd6;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_model();
      finish_cycle();
    end
    in_valid = 1'b0;
    chk("pre_rst_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_wb_data, 0);
    chk("arst_out_rd", out_rd, 0);
    chk("arst_fwd_hit", fwd_hit, 0);
    chk("arst_fwd_data", fwd_data, 0);
    chk("arst_retire", retire_count, 0);
    q.delete(); m_ret = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check_model();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
